signed_adder: RTL and testbench
===============================

Name: signed_adder

Overview:
- Reduces NUM_ADD packed two's-complement lanes from an input bus to one signed sum.
- The sum is sign-extended to the full bus width and driven on the output bus.
- Sits between a buffer read port and a buffer write port in the accelerator datapath, e.g. for partial-sum accumulation across PEs.
- Implemented as a pipelined binary adder tree with a valid bit travelling alongside the data.

Parameters:
- NUM_ADD, 4, number of signed lanes summed; must be ≥1.
- DATA_WIDTH, 8, width of each signed lane.
- BUF_WIDTH, NUM_ADD*DATA_WIDTH, input/output bus width (derived localparam, not overridable).
- LEVELS, clog2(NUM_ADD) (1 when NUM_ADD=1), tree depth = latency in cycles (derived).
- SUM_WIDTH, DATA_WIDTH+clog2(NUM_ADD), full-precision sum width (derived); elaboration error if SUM_WIDTH > BUF_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  input-valid qualifier for ibus_read_data in the current cycle.
- ibus_read_data  input  BUF_WIDTH  packed lanes; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH], signed.
- obus_write_data  output  BUF_WIDTH  registered signed sum, sign-extended to BUF_WIDTH.
- out_valid  output  1  high for one cycle when obus_write_data carries a new sum.

Behaviour:
- Reset: synchronous, active-high, takes priority over enable.
  - obus_write_data = 0 and out_valid = 0.
  - All stage data registers = 0 and all stage valid bits = 0.
- Tree, level 1:
  - Lanes are paired (0+1, 2+3, …).
  - Each operand is sign-extended by 1 bit before adding.
  - For an odd lane count, the last lane passes through sign-extended.
  - The result is registered.
- Tree, level k: same pairing on the level k-1 registers; the operand width grows 1 bit per level.
- Full precision throughout: no overflow, saturation or truncation is possible.
- Latency: a sum of inputs sampled at edge N appears on obus_write_data after edge N+LEVELS-1, i.e. LEVELS cycles. NUM_ADD=4 gives 2 cycles.
- NUM_ADD=1: a single register stage; output = the lane sign-extended, latency 1.
- Valid pipeline: valid[0] samples enable each cycle; valid[k] = valid[k-1] delayed one cycle; out_valid = final valid bit.
- The pipeline always advances; there is no back-pressure or stall input.
- Hold behaviour:
  - Stage data registers load only when their incoming valid bit is 1; otherwise they hold.
  - obus_write_data therefore holds the last valid sum while enable is low.
- Output format: bits [SUM_WIDTH-1:0] carry the sum; bits above replicate bit SUM_WIDTH-1.
- Back-to-back: enable high every cycle gives one result per cycle and out_valid stays high.
- Reset mid-operation: all in-flight sums are discarded; out_valid is 0 on the cycle after reset and stays low until LEVELS cycles after the next enable.
- Combinational input → output path: none; the output is fully registered.
- X on ibus_read_data while enable=0: must not propagate to the output.

Test Plan:
- Lanes A..D = 8'h01, 8'h02, 8'h03, 8'h04, enable=1 for one cycle → after 2 cycles obus_write_data = 32'd10 with out_valid=1 for exactly one cycle, then value held with out_valid=0.
- All lanes 8'h80 (−128) → obus_write_data = 32'hFFFF_FE00 (−512).
- All lanes 8'h7F → obus_write_data = 32'd508.
- Lanes 8'hFF, 8'h01, 8'hFE, 8'h02 → 32'd0.
- Random lanes with enable held high for 25 cycles → each output equals the sign-extended lane sum of the input 2 cycles earlier; out_valid continuously high.
- Enable low with random inputs → output frozen at the last valid sum and out_valid=0.
- Reset asserted while a sum is in flight → next cycle obus_write_data=0, out_valid=0, and the in-flight sum never appears.

Source files
------------

// File: rtl/signed_adder_if.sv
// Bus bundle between a buffer read port and a buffer write port.
// The master drives the qualified input lanes; the slave returns the reduced sum.
interface signed_adder_if #(
   parameter int BUF_WIDTH = 32
);
   logic                 enable;
   logic [BUF_WIDTH-1:0] ibus_read_data;
   logic [BUF_WIDTH-1:0] obus_write_data;
   logic                 out_valid;

   modport master (
      output enable,
      output ibus_read_data,
      input  obus_write_data,
      input  out_valid
   );

   modport slave (
      input  enable,
      input  ibus_read_data,
      output obus_write_data,
      output out_valid
   );
endinterface

// File: rtl/signed_adder.sv
// Pipelined binary adder tree reducing NUM_ADD packed signed lanes to one
// sign-extended sum. One tree level per clock, with a valid bit travelling
// alongside the data. Every partial sum is kept at SUM_WIDTH bits, which is
// wide enough for the final sum, so no level can ever overflow.
module signed_adder #(
   parameter int NUM_ADD    = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   signed_adder_if.slave bus
);

   localparam int BUF_WIDTH = NUM_ADD * DATA_WIDTH;
   localparam int LEVELS    = (NUM_ADD <= 1) ? 1 : $clog2(NUM_ADD);
   localparam int SUM_WIDTH = DATA_WIDTH + $clog2(NUM_ADD);

   if (NUM_ADD < 1) begin : g_bad_num_add
      $error("signed_adder: NUM_ADD must be at least 1");
   end

   if (SUM_WIDTH > BUF_WIDTH) begin : g_bad_sum_width
      $error("signed_adder: SUM_WIDTH does not fit in BUF_WIDTH");
   end

   // Number of operands feeding the given tree level (level 0 sees the raw lanes).
   function automatic int level_count(input int level);
      int n;
      n = NUM_ADD;
      for (int i = 0; i < level; i++) begin
         n = (n + 1) / 2;
      end
      return n;
   endfunction

   logic signed [SUM_WIDTH-1:0] lane_ext [NUM_ADD];
   logic signed [SUM_WIDTH-1:0] level_in [LEVELS][NUM_ADD];
   logic signed [SUM_WIDTH-1:0] tree_d   [LEVELS][NUM_ADD];
   logic signed [SUM_WIDTH-1:0] tree_q   [LEVELS][NUM_ADD];
   logic        [LEVELS-1:0]    in_valid;
   logic        [LEVELS-1:0]    valid_q;

   // Unpack the bus into lanes and sign-extend each lane to the full sum width.
   always_comb begin
      for (int i = 0; i < NUM_ADD; i++) begin
         lane_ext[i] = SUM_WIDTH'(signed'(bus.ibus_read_data[i*DATA_WIDTH +: DATA_WIDTH]));
      end
   end

   // Each level reads the raw lanes (level 0) or the previous level's registers,
   // and the valid bit entering a level is enable or the previous stage's valid.
   always_comb begin
      level_in[0] = lane_ext;
      in_valid[0] = bus.enable;
      for (int l = 1; l < LEVELS; l++) begin
         level_in[l] = tree_q[l-1];
         in_valid[l] = valid_q[l-1];
      end
   end

   // Pairwise sums per level; an odd operand out lands alone in its slot and so
   // passes through, and slots past the live operand count stay zero.
   always_comb begin
      for (int l = 0; l < LEVELS; l++) begin
         for (int j = 0; j < NUM_ADD; j++) begin
            tree_d[l][j] = '0;
         end
         for (int i = 0; i < NUM_ADD; i++) begin
            if (i < level_count(l)) begin
               tree_d[l][i/2] = tree_d[l][i/2] + level_in[l][i];
            end
         end
      end
   end

   // Advance the valid chain every cycle; a level's data only loads when valid
   // data is arriving, so the output holds the last sum while the bus is idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         for (int l = 0; l < LEVELS; l++) begin
            for (int j = 0; j < NUM_ADD; j++) begin
               tree_q[l][j] <= '0;
            end
         end
      end else begin
         valid_q <= in_valid;
         for (int l = 0; l < LEVELS; l++) begin
            if (in_valid[l]) begin
               tree_q[l] <= tree_d[l];
            end
         end
      end
   end

   // The final level register is the output; the signed cast sign-extends it.
   assign bus.obus_write_data = BUF_WIDTH'(tree_q[LEVELS-1][0]);
   assign bus.out_valid       = valid_q[LEVELS-1];

endmodule

// File: tb/tb_signed_adder.sv
// Directed bench for signed_adder with NUM_ADD=4, DATA_WIDTH=8 (two-cycle latency).
// Inputs are driven and outputs sampled on the falling edge.
module tb_signed_adder;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   signed_adder_if #(.BUF_WIDTH(32)) bus ();

   signed_adder #(
      .NUM_ADD   (4),
      .DATA_WIDTH(8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: sign-extended sum of the four signed byte lanes.
   function automatic logic [31:0] lane_sum(input logic [31:0] v);
      int s;
      logic signed [7:0] b;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         b = v[i*8 +: 8];
         s = s + int'(b);
      end
      return 32'(s);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [31:0] data);
      @(negedge clk);
      bus.enable         = en;
      bus.ibus_read_data = data;
   endtask

   // One isolated transaction: valid for exactly one cycle, then held.
   task automatic run_single(input string tag, input logic [31:0] data, input logic [31:0] exp);
      applyStimulus(1'b1, data);
      applyStimulus(1'b0, $urandom);
      checkOutput({tag, " early valid"}, 32'(bus.out_valid), 32'd0);
      applyStimulus(1'b0, $urandom);
      checkOutput({tag, " sum"}, bus.obus_write_data, exp);
      checkOutput({tag, " valid"}, 32'(bus.out_valid), 32'd1);
      applyStimulus(1'b0, $urandom);
      checkOutput({tag, " held"}, bus.obus_write_data, exp);
      checkOutput({tag, " valid drop"}, 32'(bus.out_valid), 32'd0);
   endtask

   logic [31:0] vecs [25];
   logic [31:0] last_sum;

   initial begin
      n_checks           = 0;
      n_fail             = 0;
      reset              = 1'b1;
      bus.enable         = 1'b0;
      bus.ibus_read_data = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset data", bus.obus_write_data, 32'd0);
      checkOutput("reset valid", 32'(bus.out_valid), 32'd0);
      reset = 1'b0;

      run_single("ascending", 32'h04030201, 32'd10);
      run_single("all min", 32'h80808080, 32'hFFFF_FE00);
      run_single("all max", 32'h7F7F7F7F, 32'd508);
      run_single("cancel", 32'h02FE01FF, 32'd0);
      run_single("mixed", 32'h807FFF01, 32'hFFFF_FFFF);

      // Back-to-back stream: result of vector c-2 visible at step c.
      for (int c = 0; c < 25; c++) begin
         vecs[c] = $urandom;
      end
      for (int c = 0; c < 27; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            checkOutput($sformatf("stream sum %0d", c - 2), bus.obus_write_data, lane_sum(vecs[c-2]));
            checkOutput($sformatf("stream valid %0d", c - 2), 32'(bus.out_valid), 32'd1);
         end
         if (c < 25) begin
            bus.enable         = 1'b1;
            bus.ibus_read_data = vecs[c];
         end else begin
            bus.enable         = 1'b0;
            bus.ibus_read_data = $urandom;
         end
      end
      last_sum = lane_sum(vecs[24]);

      // Idle with changing inputs: output frozen, no valid.
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b0, $urandom);
         checkOutput($sformatf("idle hold %0d", c), bus.obus_write_data, last_sum);
         checkOutput($sformatf("idle valid %0d", c), 32'(bus.out_valid), 32'd0);
      end

      // Reset while a sum is half way down the tree.
      applyStimulus(1'b1, 32'h11223344);
      @(negedge clk);
      bus.enable = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      checkOutput("flush data", bus.obus_write_data, 32'd0);
      checkOutput("flush valid", 32'(bus.out_valid), 32'd0);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, $urandom);
         checkOutput($sformatf("post flush data %0d", c), bus.obus_write_data, 32'd0);
         checkOutput($sformatf("post flush valid %0d", c), 32'(bus.out_valid), 32'd0);
      end

      run_single("recover", 32'h01010101, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule
